// File: rtl/team_06_wb_gpio_bank.sv
// rtl/team_06_wb_gpio_bank.sv - Wishbone-slave GPIO register bank with optional edge interrupts
//
// Purpose: owns gpio_out/gpio_oeb for NUM_GPIO pads behind a Wishbone slave port.
//   Provides output and direction registers, set/clear aliases, synchronised
//   input readback and, when GPIO_BANK_IRQ_EN is defined, rising-edge interrupts.
//   Without GPIO_BANK_IRQ_EN the mask/status registers read 0 and irq is tied 0.
//
// Ports:
//   wb_clk_i   in   1         sole clock
//   wb_rst_i   in   1         synchronous reset, active-high
//   wbs_stb_i  in   1         strobe
//   wbs_cyc_i  in   1         cycle
//   wbs_we_i   in   1         1 = write
//   wbs_sel_i  in   4         byte lane enables
//   wbs_adr_i  in   32        byte address
//   wbs_dat_i  in   32        write data
//   wbs_ack_o  out  1         single-cycle acknowledge
//   wbs_dat_o  out  32        read data, valid with ack
//   gpio_in    in   NUM_GPIO  raw pad inputs, asynchronous
//   gpio_out   out  NUM_GPIO  pad output values
//   gpio_oeb   out  NUM_GPIO  active-low output enable
//   irq        out  1         level interrupt

module team_06_wb_gpio_bank #(
    parameter int unsigned NUM_GPIO    = 38,
    parameter logic [63:0] RSVD_MASK   = 64'h1E,
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                wbs_stb_i,
    input  logic                wbs_cyc_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_adr_i,
    input  logic [31:0]         wbs_dat_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_dat_o,
    input  logic [NUM_GPIO-1:0] gpio_in,
    output logic [NUM_GPIO-1:0] gpio_out,
    output logic [NUM_GPIO-1:0] gpio_oeb,
    output logic                irq
);

    // Pins that exist, pins that are reserved, and pins whose state is stored.
    localparam logic [63:0] NUM_MASK = {64{1'b1}} >> (64 - NUM_GPIO);
    localparam logic [63:0] RSVD     = RSVD_MASK & NUM_MASK;
    localparam logic [63:0] WR_MASK  = NUM_MASK & ~RSVD_MASK;

    // Register select = adr[5:3]; adr[2] picks the lo/hi word.
    localparam logic [2:0] R_OUT = 3'd0;
    localparam logic [2:0] R_OEB = 3'd1;
    localparam logic [2:0] R_IN  = 3'd2;
    localparam logic [2:0] R_SET = 3'd3;
    localparam logic [2:0] R_CLR = 3'd4;
    localparam logic [2:0] R_MSK = 3'd5;
    localparam logic [2:0] R_STA = 3'd6;

    logic                ack_q;
    logic [31:0]         dat_q, dat_d;
    logic [63:0]         out_q, out_d;
    logic [63:0]         oeb_q, oeb_d;
    logic [NUM_GPIO-1:0] sync_q [SYNC_STAGES];
    logic [63:0]         in_sync;
    logic [63:0]         msk_rd, sta_rd;

    logic        req, in_win, hi, wr_en;
    logic [2:0]  rsel;
    logic [31:0] lane32;
    logic [63:0] lane_m, wbits, rd64;
    logic [1:0]  unused_adr;

    assign unused_adr = wbs_adr_i[1:0];

    // The ~ack term turns a held strobe into one request every other cycle.
    assign req    = wbs_stb_i & wbs_cyc_i & ~ack_q;
    assign in_win = (wbs_adr_i[31:6] == BASE_ADDR[31:6]);
    assign rsel   = wbs_adr_i[5:3];
    assign hi     = wbs_adr_i[2];
    assign wr_en  = req & wbs_we_i & in_win;

    assign lane32 = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                     {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    assign lane_m = hi ? {lane32, 32'h0} : {32'h0, lane32};
    // Write data replicated into both halves; lane_m selects the addressed word.
    assign wbits  = {wbs_dat_i, wbs_dat_i} & lane_m;

    assign in_sync = 64'(sync_q[SYNC_STAGES-1]);

    always_comb begin
        out_d = out_q;
        oeb_d = oeb_q;
        if (wr_en) begin
            case (rsel)
                R_OUT:   out_d = (out_q & ~lane_m) | wbits;
                R_SET:   out_d = out_q | wbits;
                R_CLR:   out_d = out_q & ~wbits;
                R_OEB:   oeb_d = (oeb_q & ~lane_m) | wbits;
                default: ;
            endcase
        end
        out_d = out_d & WR_MASK;
        oeb_d = oeb_d & WR_MASK;
    end

`ifdef GPIO_BANK_IRQ_EN
    logic [63:0] msk_q, msk_d;
    logic [63:0] sta_q, sta_d;
    logic [63:0] prev_q, rise, w1c;
    logic        irq_q;

    // Edge detect on the fully synchronised value against its previous sample,
    // so no metastable stage ever feeds the status logic.
    assign rise = in_sync & ~prev_q & WR_MASK;
    assign w1c  = (wr_en && rsel == R_STA) ? wbits : 64'h0;

    always_comb begin
        msk_d = msk_q;
        if (wr_en && rsel == R_MSK) begin
            msk_d = (msk_q & ~lane_m) | wbits;
        end
        msk_d = msk_d & WR_MASK;
        // OR-ing rise after the clear makes a coincident edge win over W1C.
        sta_d = ((sta_q & ~w1c) | rise) & WR_MASK;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            msk_q  <= '0;
            sta_q  <= '0;
            prev_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            msk_q  <= msk_d;
            sta_q  <= sta_d;
            prev_q <= in_sync;
            irq_q  <= |(sta_q & msk_q);
        end
    end

    assign msk_rd = msk_q;
    assign sta_rd = sta_q;
    assign irq    = irq_q;
`else
    assign msk_rd = 64'h0;
    assign sta_rd = 64'h0;
    assign irq    = 1'b0;
`endif

    always_comb begin
        rd64 = 64'h0;
        case (rsel)
            R_OUT:   rd64 = out_q;
            R_OEB:   rd64 = (oeb_q | RSVD) & NUM_MASK;
            R_IN:    rd64 = in_sync;
            R_MSK:   rd64 = msk_rd;
            R_STA:   rd64 = sta_rd;
            default: rd64 = 64'h0;
        endcase
        dat_d = 32'h0;
        if (req && in_win && !wbs_we_i) begin
            dat_d = hi ? rd64[63:32] : rd64[31:0];
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q <= 1'b0;
            dat_q <= 32'h0;
            out_q <= '0;
            oeb_q <= WR_MASK;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            ack_q <= req;
            dat_q <= dat_d;
            out_q <= out_d;
            oeb_q <= oeb_d;
            sync_q[0] <= gpio_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign gpio_out  = out_q[NUM_GPIO-1:0];
    assign gpio_oeb  = oeb_q[NUM_GPIO-1:0] | RSVD[NUM_GPIO-1:0];

endmodule

// File: tb/tb_team_06_wb_gpio_bank.sv
// tb/tb_team_06_wb_gpio_bank.sv - self-checking bench for team_06_wb_gpio_bank

module tb_team_06_wb_gpio_bank;

    localparam int          NUM  = 38;
    localparam logic [63:0] RSVD = 64'h1E;
    localparam logic [31:0] BASE = 32'h3000_0000;
`ifdef GPIO_BANK_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            stb, cyc, we;
    logic [3:0]      sel;
    logic [31:0]     adr, dat_i;
    logic            ack;
    logic [31:0]     dat_o;
    logic [NUM-1:0]  gpio_in, gpio_out, gpio_oeb;
    logic            irq;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    team_06_wb_gpio_bank dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_stb_i (stb),
        .wbs_cyc_i (cyc),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (dat_i),
        .wbs_ack_o (ack),
        .wbs_dat_o (dat_o),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .gpio_oeb  (gpio_oeb),
        .irq       (irq)
    );

    // Per-pin reference state.
    bit m_out [64];
    bit m_oeb [64];
    bit m_msk [64];
    bit m_sta [64];
    bit m_in  [64];

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    function automatic bit stored(input int p);
        return (p < NUM) && !RSVD[p];
    endfunction

    task automatic model_reset();
        for (int p = 0; p < 64; p++) begin
            m_out[p] = 1'b0; m_oeb[p] = 1'b1; m_msk[p] = 1'b0;
            m_sta[p] = 1'b0; m_in[p]  = 1'b0;
        end
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] r;
        int p;
        r = 32'h0;
        if (a[31:6] == BASE[31:6]) begin
            for (int b = 0; b < 32; b++) begin
                p = 32 * int'(a[2]) + b;
                if (p < NUM) begin
                    case (a[5:3])
                        3'd0:    r[b] = m_out[p];
                        3'd1:    r[b] = RSVD[p] | m_oeb[p];
                        3'd2:    r[b] = m_in[p];
                        3'd5:    r[b] = IRQ_EN & m_msk[p];
                        3'd6:    r[b] = IRQ_EN & m_sta[p];
                        default: r[b] = 1'b0;
                    endcase
                end
            end
        end
        return r;
    endfunction

    task automatic m_write(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        int p;
        if (a[31:6] != BASE[31:6]) return;
        for (int b = 0; b < 32; b++) begin
            p = 32 * int'(a[2]) + b;
            if (stored(p) && s[b/8]) begin
                case (a[5:3])
                    3'd0: m_out[p] = d[b];
                    3'd1: m_oeb[p] = d[b];
                    3'd3: if (d[b]) m_out[p] = 1'b1;
                    3'd4: if (d[b]) m_out[p] = 1'b0;
                    3'd5: m_msk[p] = IRQ_EN & d[b];
                    3'd6: if (d[b]) m_sta[p] = 1'b0;
                    default: ;
                endcase
            end
        end
    endtask

    function automatic logic m_irq();
        logic r;
        r = 1'b0;
        for (int p = 0; p < NUM; p++) r = r | (IRQ_EN & m_msk[p] & m_sta[p]);
        return r;
    endfunction

    // Drive new pad values; rising edges on stored pins latch status.
    task automatic set_pins(input logic [63:0] v);
        for (int p = 0; p < NUM; p++) begin
            if (IRQ_EN && stored(p) && !m_in[p] && v[p]) m_sta[p] = 1'b1;
            m_in[p] = v[p];
        end
        gpio_in = v[NUM-1:0];
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_pins(input string nm);
        logic [NUM-1:0] eo, ee;
        for (int p = 0; p < NUM; p++) begin
            eo[p] = m_out[p];
            ee[p] = RSVD[p] | m_oeb[p];
        end
        chk({nm, "_gpio_out"}, 64'(gpio_out), 64'(eo));
        chk({nm, "_gpio_oeb"}, 64'(gpio_oeb), 64'(ee));
        chk({nm, "_irq"}, 64'(irq), 64'(m_irq()));
    endtask

    // Called at posedge+1; returns at posedge+1 one cycle after the ack.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, output logic [31:0] rd,
                        output int lat, output logic ack_after);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; sel = s; dat_i = d;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!ack && lat < 8);
        rd = dat_o;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        ack_after = ack;
    endtask

    task automatic do_wr(input string nm, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        logic [31:0] rd;
        int lat;
        logic aa;
        xfer(1'b1, a, s, d, rd, lat, aa);
        chk({nm, "_lat"}, 64'(lat), 64'd1);
        m_write(a, s, d);
    endtask

    task automatic do_rd(input string nm, input logic [31:0] a, output logic [31:0] rd);
        int lat;
        logic aa;
        xfer(1'b0, a, 4'hF, 32'h0, rd, lat, aa);
        chk({nm, "_lat"}, 64'(lat), 64'd1);
    endtask

    task automatic add_vec(input logic w, input logic [31:0] a, input logic [3:0] s,
                           input logic [31:0] d, input logic [31:0] e);
        vec_t v;
        v.we = w; v.adr = a; v.sel = s; v.dat = d; v.exp = e;
        tbl.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, a, d;
        logic [3:0]  s;
        logic        w, aa;
        int          lat, cnt;

        rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0;
        sel = 4'h0; adr = 32'h0; dat_i = 32'h0; gpio_in = '0;
        model_reset();

        // Reset state
        wait_cyc(3);
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_dat", 64'(dat_o), 64'd0);
        chk("rst_gpio_out", 64'(gpio_out), 64'd0);
        chk("rst_gpio_oeb", 64'(gpio_oeb), 64'h3F_FFFF_FFFF);
        chk("rst_irq", 64'(irq), 64'd0);
        rst = 1'b0;
        wait_cyc(1);

        // Vector table
        add_vec(0, BASE + 32'h08, 4'hF, 32'h0, 32'hFFFF_FFFF);
        add_vec(0, BASE + 32'h0C, 4'hF, 32'h0, 32'h0000_003F);
        add_vec(0, BASE + 32'h00, 4'hF, 32'h0, 32'h0);
        add_vec(0, BASE + 32'h10, 4'hF, 32'h0, 32'h0);
        add_vec(1, BASE + 32'h00, 4'hF, 32'hFFFF_FFFF, 32'h0);
        add_vec(1, BASE + 32'h08, 4'hF, 32'h0, 32'h0);
        add_vec(0, BASE + 32'h00, 4'hF, 32'h0, 32'hFFFF_FFE1);
        add_vec(0, BASE + 32'h08, 4'hF, 32'h0, 32'h0000_001E);
        add_vec(1, BASE + 32'h00, 4'hF, 32'h0000_00F0, 32'h0);
        add_vec(1, BASE + 32'h18, 4'hF, 32'h0000_0F00, 32'h0);
        add_vec(1, BASE + 32'h20, 4'hF, 32'h0000_0030, 32'h0);
        add_vec(0, BASE + 32'h00, 4'hF, 32'h0, 32'h0000_0FC0);
        add_vec(0, BASE + 32'h18, 4'hF, 32'h0, 32'h0);
        add_vec(0, BASE + 32'h20, 4'hF, 32'h0, 32'h0);
        add_vec(1, BASE + 32'h00, 4'b0010, 32'hAABB_CCDD, 32'h0);
        add_vec(0, BASE + 32'h00, 4'hF, 32'h0, 32'h0000_CCC0);
        add_vec(1, BASE + 32'h04, 4'hF, 32'hFFFF_FFFF, 32'h0);
        add_vec(0, BASE + 32'h04, 4'hF, 32'h0, 32'h0000_003F);
        add_vec(1, BASE + 32'h40, 4'hF, 32'h1234_5678, 32'h0);
        add_vec(0, BASE + 32'h40, 4'hF, 32'h0, 32'h0);
        add_vec(1, BASE - 32'h4, 4'hF, 32'hFFFF_FFFF, 32'h0);
        add_vec(0, BASE - 32'h4, 4'hF, 32'h0, 32'h0);
        add_vec(0, BASE + 32'h00, 4'hF, 32'h0, 32'h0000_CCC0);
        add_vec(1, BASE + 32'h3C, 4'hF, 32'hFFFF_FFFF, 32'h0);
        add_vec(0, BASE + 32'h3C, 4'hF, 32'h0, 32'h0);
        add_vec(1, BASE + 32'h28, 4'hF, 32'hFFFF_FFFF, 32'h0);
`ifdef GPIO_BANK_IRQ_EN
        add_vec(0, BASE + 32'h28, 4'hF, 32'h0, 32'hFFFF_FFE1);
`else
        add_vec(0, BASE + 32'h28, 4'hF, 32'h0, 32'h0);
`endif
        add_vec(0, BASE + 32'h30, 4'hF, 32'h0, 32'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            xfer(tbl[i].we, tbl[i].adr, tbl[i].sel, tbl[i].dat, rd, lat, aa);
            chk($sformatf("tbl%0d_lat", i), 64'(lat), 64'd1);
            chk($sformatf("tbl%0d_ack_once", i), 64'(aa), 64'd0);
            if (tbl[i].we) m_write(tbl[i].adr, tbl[i].sel, tbl[i].dat);
            else chk($sformatf("tbl%0d_rdata", i), 64'(rd), 64'(tbl[i].exp));
            chk_pins($sformatf("tbl%0d", i));
        end
        chk("rsvd_oeb", 64'(gpio_oeb[4:1]), 64'hF);
        chk("rsvd_out", 64'(gpio_out[4:1]), 64'h0);
        chk("pin0_oeb", 64'(gpio_oeb[0]), 64'h0);

        // Input readback lag: a read issued with the pad change sees the old value.
        set_pins(64'h15_A5A5_5A5A);
        do_rd("in_lag", BASE + 32'h10, rd);
        chk("in_lag_old", 64'(rd), 64'h0);
        do_rd("in_lo", BASE + 32'h10, rd);
        chk("in_lo_new", 64'(rd), 64'hA5A5_5A5A);
        do_rd("in_hi", BASE + 32'h14, rd);
        chk("in_hi_new", 64'(rd), 64'h15);
        wait_cyc(2);
        chk_pins("in_settle");

`ifdef GPIO_BANK_IRQ_EN
        // Interrupt latency, W1C, and edge-beats-W1C.
        set_pins(64'h0);
        wait_cyc(4);
        do_wr("irq_msk_lo", BASE + 32'h28, 4'hF, 32'h0000_0020);
        do_wr("irq_msk_hi", BASE + 32'h2C, 4'hF, 32'h0);
        do_wr("irq_clr_lo", BASE + 32'h30, 4'hF, 32'hFFFF_FFFF);
        do_wr("irq_clr_hi", BASE + 32'h34, 4'hF, 32'hFFFF_FFFF);
        chk("irq_idle", 64'(irq), 64'd0);
        set_pins(64'h20);
        cnt = 0;
        do begin
            @(posedge clk); #1;
            cnt++;
        end while (!irq && cnt < 8);
        chk("irq_by_cycle4", 64'(cnt <= 4), 64'd1);
        do_rd("irq_sta", BASE + 32'h30, rd);
        chk("irq_sta_val", 64'(rd), 64'h20);
        do_wr("irq_w1c", BASE + 32'h30, 4'hF, 32'h20);
        chk("irq_after_w1c", 64'(irq), 64'd0);
        set_pins(64'h0);
        wait_cyc(4);
        set_pins(64'h20);
        @(posedge clk);
        @(posedge clk);
        #1;
        xfer(1'b1, BASE + 32'h30, 4'hF, 32'h20, rd, lat, aa);
        chk("irq_coinc_lat", 64'(lat), 64'd1);
        do_rd("irq_coinc", BASE + 32'h30, rd);
        chk("irq_coinc_sta", 64'(rd), 64'h20);
        chk_pins("irq_coinc");
`endif

        // Randomised traffic against the reference model.
        for (int n = 0; n < 300; n++) begin
            if (n % 25 == 0) begin
                set_pins({$urandom, $urandom});
                wait_cyc(4);
            end
            a = BASE + 32'($urandom_range(0, 15) * 4);
            if ($urandom_range(0, 9) == 0) a = a + 32'h40;
            else if ($urandom_range(0, 9) == 0) a = BASE - 32'($urandom_range(1, 16) * 4);
            w = 1'($urandom_range(0, 1));
            s = 4'($urandom);
            d = $urandom;
            xfer(w, a, s, d, rd, lat, aa);
            chk($sformatf("rnd%0d_lat", n), 64'(lat), 64'd1);
            if (w) m_write(a, s, d);
            else chk($sformatf("rnd%0d_rd_%h", n, a), 64'(rd), 64'(m_read(a)));
            chk_pins($sformatf("rnd%0d", n));
        end

        // Reset arriving with a pending request: no ack, write dropped.
        do_wr("pre_rst", BASE + 32'h00, 4'hF, 32'h0000_FF00);
        rst = 1'b1; stb = 1'b1; cyc = 1'b1; we = 1'b1;
        adr = BASE; sel = 4'hF; dat_i = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        chk("midrst_no_ack", 64'(ack), 64'd0);
        rst = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0;
        model_reset();
        set_pins(64'(gpio_in));
        wait_cyc(4);
        do_rd("midrst_out", BASE + 32'h00, rd);
        chk("midrst_out_val", 64'(rd), 64'h0);
        do_rd("midrst_oeb", BASE + 32'h08, rd);
        chk("midrst_oeb_val", 64'(rd), 64'hFFFF_FFFF);
        chk_pins("midrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
